ram_read_scheduler: RTL and testbench

//  Sequences tagged read requests from the out-of-order core onto both read ports of single_blockram.

---
 rtl/ram_sched_pkg.sv | 29 ++
 rtl/ram_req_fifo.sv | 58 +++++
 rtl/ram_read_scheduler.sv | 114 +++++++++++
 tb/tb_ram_read_scheduler.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_sched_pkg.sv
// Shared types and default sizes for the RAM read scheduler.
package ram_sched_pkg;

  localparam int REQ_DEPTH_DEF = 8;
  localparam int ADDR_W_DEF    = 16;
  localparam int DATA_W_DEF    = 16;
  localparam int TAG_W_DEF     = 8;
  localparam int RAM_WORDS_DEF = 700;

  // One queued read: where to read and which instruction it belongs to.
  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [TAG_W_DEF-1:0]  tag;
  } readram_req;

  // One returned result lane.
  typedef struct packed {
    logic                  valid;
    logic [TAG_W_DEF-1:0]  tag;
    logic [DATA_W_DEF-1:0] value;
    logic                  error;
  } readram_rsp;

  // Number of set bits in a 2-lane valid mask.
  function automatic logic [1:0] lane_count(input logic [1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]};
  endfunction

endpackage

// File: rtl/ram_req_fifo.sv
// Two-in / two-out circular request buffer. Pushed lanes are packed into
// consecutive slots (lane 0 first); head and head+1 are always visible.
module ram_req_fifo
  import ram_sched_pkg::*;
#(
  parameter  int DEPTH = REQ_DEPTH_DEF,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       push,
  input  readram_req       push_data0,
  input  readram_req       push_data1,
  input  logic [1:0]       pop_n,
  output readram_req       head,
  output readram_req       head1,
  output logic [CNT_W-1:0] count
);

  readram_req       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr1;
  logic [1:0]       n_push;

  assign n_push  = lane_count(push);
  assign wr_ptr1 = wr_ptr + PTR_W'(1);
  assign head    = mem[rd_ptr];
  assign head1   = mem[rd_ptr + PTR_W'(1)];

  // Slot writes: lane 1 takes the first free slot when lane 0 is absent.
  // NOTE: storage is not reset; count and pointers alone say which slots hold live requests.
  always_ff @(posedge clk) begin
    if (push[0]) mem[wr_ptr] <= push_data0;
    if (push[1]) mem[push[0] ? wr_ptr1 : wr_ptr] <= push_data1;
  end

  // Pointer and occupancy update; pointers wrap naturally at DEPTH (power of two).
  // NOTE: non-blocking so count, wr_ptr and rd_ptr all see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(n_push);
      rd_ptr <= rd_ptr + PTR_W'(pop_n);
      count  <= count - CNT_W'(pop_n) + CNT_W'(n_push);
    end
  end

  // Occupancy must never exceed the buffer size.
  always_ff @(posedge clk) begin
    if (!rst) assert (count <= CNT_W'(DEPTH));
  end

endmodule

// File: rtl/ram_read_scheduler.sv
// Issues buffered tagged reads onto both RAM read ports, registers the
// results with their tags, and passes the write port through with
// same-cycle write-to-read forwarding and address range checking.
module ram_read_scheduler
  import ram_sched_pkg::*;
#(
  parameter int REQ_DEPTH = REQ_DEPTH_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int TAG_W     = TAG_W_DEF,
  parameter int RAM_WORDS = RAM_WORDS_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_valid,
  input  logic [2*ADDR_W-1:0] req_address,
  input  logic [2*TAG_W-1:0]  req_tag,
  output logic                req_ready,
  input  logic                rsp_stall,
  output logic [1:0]          rsp_valid,
  output logic [2*TAG_W-1:0]  rsp_tag,
  output logic [2*DATA_W-1:0] rsp_value,
  output logic [1:0]          rsp_error,
  input  logic                wr_valid,
  input  logic [ADDR_W-1:0]   wr_address,
  input  logic [DATA_W-1:0]   wr_value,
  output logic                ram_write_enabled,
  output logic [ADDR_W-1:0]   ram_write_address,
  output logic [DATA_W-1:0]   ram_write_value,
  output logic [ADDR_W-1:0]   ram_read_address,
  input  logic [DATA_W-1:0]   ram_read_value,
  output logic [ADDR_W-1:0]   ram_read_address2,
  input  logic [DATA_W-1:0]   ram_read_value2
);

  localparam int CNT_W = $clog2(REQ_DEPTH) + 1;

  logic [CNT_W-1:0]  count;
  logic [1:0]        push;
  logic [1:0]        issue;
  logic [1:0]        pop_n;
  readram_req        in0, in1, head, head1;
  readram_req        lane_req [2];
  logic [DATA_W-1:0] lane_ram [2];
  readram_rsp [1:0]  rsp_d, rsp_q;

  // Ready only with two free slots, so a dual-lane push can never overflow.
  assign req_ready = (count <= CNT_W'(REQ_DEPTH - 2));
  assign push      = req_ready ? req_valid : 2'b00;
  assign in0       = '{addr: req_address[ADDR_W-1:0],      tag: req_tag[TAG_W-1:0]};
  assign in1       = '{addr: req_address[2*ADDR_W-1:ADDR_W], tag: req_tag[2*TAG_W-1:TAG_W]};

  ram_req_fifo #(.DEPTH(REQ_DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_data0 (in0),
    .push_data1 (in1),
    .pop_n      (pop_n),
    .head       (head),
    .head1      (head1),
    .count      (count)
  );

  // Write port pass-through; out-of-range writes are suppressed.
  assign ram_write_enabled = wr_valid && (wr_address < ADDR_W'(RAM_WORDS));
  assign ram_write_address = wr_address;
  assign ram_write_value   = wr_value;

  // Both read ports always look at the head pair, issued or not.
  assign ram_read_address  = head.addr;
  assign ram_read_address2 = head1.addr;
  assign lane_req[0] = head;
  assign lane_req[1] = head1;
  assign lane_ram[0] = ram_read_value;
  assign lane_ram[1] = ram_read_value2;

  // Issue mask: up to two of the oldest entries unless stalled or empty.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    issue = 2'b00;
    if (!rsp_stall && count != '0) issue = (count == CNT_W'(1)) ? 2'b01 : 2'b11;
  end

  assign pop_n = issue[1] ? 2'd2 : {1'b0, issue[0]};

  // Next response per lane: range error wins, then forwarding, then RAM data.
  always_comb begin
    rsp_d = '0;
    for (int i = 0; i < 2; i++) begin
      if (issue[i]) begin
        rsp_d[i].valid = 1'b1;
        rsp_d[i].tag   = lane_req[i].tag;
        if (lane_req[i].addr >= ADDR_W'(RAM_WORDS)) rsp_d[i].error = 1'b1;
        else if (wr_valid && lane_req[i].addr == wr_address) rsp_d[i].value = wr_value;
        else rsp_d[i].value = lane_ram[i];
      end
    end
  end

  // Response registers: results appear one cycle after issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rsp_q <= '0;
    else     rsp_q <= rsp_d;
  end

  for (genvar i = 0; i < 2; i++) begin : g_out
    assign rsp_valid[i]                    = rsp_q[i].valid;
    assign rsp_tag[i*TAG_W +: TAG_W]       = rsp_q[i].tag;
    assign rsp_value[i*DATA_W +: DATA_W]   = rsp_q[i].value;
    assign rsp_error[i]                    = rsp_q[i].error;
  end

endmodule

// File: tb/tb_ram_read_scheduler.sv
// Self-checking bench for ram_read_scheduler: a behavioural RAM drives the
// read ports, and a queue-based reference model predicts every response.
module tb_ram_read_scheduler;

  localparam int DEPTH = 8;
  localparam int WORDS = 700;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [31:0] req_address;
  logic [15:0] req_tag;
  logic        req_ready;
  logic        rsp_stall;
  logic [1:0]  rsp_valid;
  logic [15:0] rsp_tag;
  logic [31:0] rsp_value;
  logic [1:0]  rsp_error;
  logic        wr_valid;
  logic [15:0] wr_address;
  logic [15:0] wr_value;
  logic        ram_write_enabled;
  logic [15:0] ram_write_address;
  logic [15:0] ram_write_value;
  logic [15:0] ram_read_address;
  logic [15:0] ram_read_value;
  logic [15:0] ram_read_address2;
  logic [15:0] ram_read_value2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  tag;
  } mreq_t;

  mreq_t       pq [$];
  logic [7:0]  sent [$];
  logic [7:0]  got  [$];
  logic [15:0] ref_ram [WORDS];
  logic [15:0] tb_ram  [WORDS];
  int          last_acc;
  logic [7:0]  tagc;

  always #5 clk = ~clk;

  ram_read_scheduler dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid         (req_valid),
    .req_address       (req_address),
    .req_tag           (req_tag),
    .req_ready         (req_ready),
    .rsp_stall         (rsp_stall),
    .rsp_valid         (rsp_valid),
    .rsp_tag           (rsp_tag),
    .rsp_value         (rsp_value),
    .rsp_error         (rsp_error),
    .wr_valid          (wr_valid),
    .wr_address        (wr_address),
    .wr_value          (wr_value),
    .ram_write_enabled (ram_write_enabled),
    .ram_write_address (ram_write_address),
    .ram_write_value   (ram_write_value),
    .ram_read_address  (ram_read_address),
    .ram_read_value    (ram_read_value),
    .ram_read_address2 (ram_read_address2),
    .ram_read_value2   (ram_read_value2)
  );

  // Behavioural block RAM: combinational reads, clocked writes.
  assign ram_read_value  = (ram_read_address  < 16'(WORDS)) ? tb_ram[ram_read_address]  : 16'hDEAD;
  assign ram_read_value2 = (ram_read_address2 < 16'(WORDS)) ? tb_ram[ram_read_address2] : 16'hDEAD;

  always @(posedge clk) begin
    if (ram_write_enabled && ram_write_address < 16'(WORDS)) tb_ram[ram_write_address] <= ram_write_value;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  // One clock cycle: apply inputs, predict, clock, update model, compare.
  task automatic step(input logic [1:0] v, input logic [15:0] a0, input logic [15:0] a1,
                      input logic [7:0] t0, input logic [7:0] t1, input logic stall,
                      input logic wv, input logic [15:0] wa, input logic [15:0] wd);
    logic [1:0]  ev;
    logic [7:0]  et [2];
    logic [15:0] eval [2];
    logic [1:0]  eerr;
    bit          exp_ready;
    int          k;
    req_valid   = v;
    req_address = {a1, a0};
    req_tag     = {t1, t0};
    rsp_stall   = stall;
    wr_valid    = wv;
    wr_address  = wa;
    wr_value    = wd;
    exp_ready = (pq.size() <= DEPTH - 2);
    k = stall ? 0 : ((pq.size() >= 2) ? 2 : pq.size());
    ev = 2'b00;
    eerr = 2'b00;
    for (int i = 0; i < 2; i++) begin
      et[i] = 8'h00;
      eval[i] = 16'h0000;
      if (i < k) begin
        ev[i] = 1'b1;
        et[i] = pq[i].tag;
        if (pq[i].addr >= 16'(WORDS)) eerr[i] = 1'b1;
        else if (wv && wa == pq[i].addr) eval[i] = wd;
        else eval[i] = ref_ram[pq[i].addr];
      end
    end
    #1;
    checks++;
    if (req_ready !== exp_ready) begin
      errors++;
      $display("FAIL req_ready: got %b required %b (queued %0d)", req_ready, exp_ready, pq.size());
    end
    checks++;
    if (ram_write_enabled !== (wv && wa < 16'(WORDS))) begin
      errors++;
      $display("FAIL ram_write_enabled: got %b required %b (addr %0d)", ram_write_enabled, (wv && wa < 16'(WORDS)), wa);
    end
    @(posedge clk);
    for (int i = 0; i < k; i++) void'(pq.pop_front());
    last_acc = 0;
    if (exp_ready) begin
      if (v[0]) begin pq.push_back('{addr: a0, tag: t0}); sent.push_back(t0); last_acc++; end
      if (v[1]) begin pq.push_back('{addr: a1, tag: t1}); sent.push_back(t1); last_acc++; end
    end
    if (wv && wa < 16'(WORDS)) ref_ram[wa] = wd;
    #1;
    checks++;
    if (rsp_valid !== ev) begin
      errors++;
      $display("FAIL rsp_valid: got %b required %b", rsp_valid, ev);
    end
    for (int i = 0; i < 2; i++) begin
      if (ev[i] && rsp_valid[i]) begin
        got.push_back(rsp_tag[i*8 +: 8]);
        checks++;
        if (rsp_tag[i*8 +: 8] !== et[i] || rsp_value[i*16 +: 16] !== eval[i] || rsp_error[i] !== eerr[i]) begin
          errors++;
          $display("FAIL rsp_lane%0d: got tag %h value %h err %b required tag %h value %h err %b", i,
                   rsp_tag[i*8 +: 8], rsp_value[i*16 +: 16], rsp_error[i], et[i], eval[i], eerr[i]);
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'b00, 16'h0, 16'h0, 8'h0, 8'h0, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic check_order(input string name);
    checks++;
    if (sent.size() != got.size()) begin
      errors++;
      $display("FAIL %s_count: got %0d responses required %0d", name, got.size(), sent.size());
    end else begin
      for (int i = 0; i < sent.size(); i++) begin
        checks++;
        if (got[i] !== sent[i]) begin
          errors++;
          $display("FAIL %s_order[%0d]: got tag %h required %h", name, i, got[i], sent[i]);
        end
      end
    end
    sent.delete();
    got.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    checks++;
    if (rsp_valid !== 2'b00 || rsp_tag !== 16'h0 || rsp_value !== 32'h0 || rsp_error !== 2'b00 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: got valid %b tag %h value %h err %b ready %b required 00/0/0/00/1",
               rsp_valid, rsp_tag, rsp_value, rsp_error, req_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    // Queue five requests under stall, then let two issue and reset mid-cycle.
    step(2'b11, 16'd10, 16'd11, 8'd90, 8'd91, 1'b1, 1'b0, 16'h0, 16'h0);
    step(2'b11, 16'd12, 16'd13, 8'd92, 8'd93, 1'b1, 1'b0, 16'h0, 16'h0);
    step(2'b01, 16'd14, 16'd0,  8'd94, 8'd0,  1'b1, 1'b0, 16'h0, 16'h0);
    step(2'b00, 16'd0,  16'd0,  8'd0,  8'd0,  1'b0, 1'b0, 16'h0, 16'h0);
    rst = 1'b1;
    #2;
    checks++;
    if (rsp_valid !== 2'b00 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: got valid %b ready %b required 00 1", rsp_valid, req_ready);
    end
    rst = 1'b0;
    pq.delete();
    sent.delete();
    got.delete();
    idle(3);
  endtask

  task automatic test_single_lane();
    step(2'b01, 16'd52, 16'd0, 8'd0, 8'd0, 1'b0, 1'b0, 16'h0, 16'h0);
    step(2'b01, 16'd54, 16'd0, 8'd1, 8'd0, 1'b0, 1'b0, 16'h0, 16'h0);
    idle(2);
    // Lane 1 alone must also be accepted.
    step(2'b10, 16'd0, 16'd54, 8'd0, 8'd2, 1'b0, 1'b0, 16'h0, 16'h0);
    idle(2);
    check_order("single");
  endtask

  task automatic test_dual_issue();
    step(2'b11, 16'd50, 16'd51, 8'd3, 8'd4, 1'b0, 1'b0, 16'h0, 16'h0);
    idle(2);
    check_order("dual");
  endtask

  task automatic test_forwarding();
    step(2'b01, 16'd52, 16'd0, 8'd5, 8'd0, 1'b0, 1'b0, 16'h0, 16'h0);
    step(2'b00, 16'd0, 16'd0, 8'd0, 8'd0, 1'b0, 1'b1, 16'd52, 16'hBEEF);
    idle(1);
    step(2'b01, 16'd52, 16'd0, 8'd6, 8'd0, 1'b0, 1'b0, 16'h0, 16'h0);
    idle(2);
    check_order("forward");
  endtask

  task automatic test_range();
    step(2'b01, 16'd700, 16'd0, 8'd7, 8'd0, 1'b0, 1'b1, 16'd699, 16'hCAFE);
    step(2'b00, 16'd0, 16'd0, 8'd0, 8'd0, 1'b0, 1'b1, 16'd700, 16'h1234);
    step(2'b01, 16'd699, 16'd0, 8'd8, 8'd0, 1'b0, 1'b0, 16'h0, 16'h0);
    idle(2);
    check_order("range");
  endtask

  task automatic test_full_wrap();
    tagc = 8'd20;
    for (int i = 0; i < 6; i++) begin
      step(2'b11, 16'($urandom_range(0, 699)), 16'($urandom_range(0, 699)), tagc, tagc + 8'd1,
           1'b1, 1'b0, 16'h0, 16'h0);
      tagc += 8'(last_acc);
    end
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_ready: got %b required 0", req_ready);
    end
    for (int i = 0; i < 20; i++) begin
      step(2'b11, 16'($urandom_range(0, 699)), 16'($urandom_range(0, 699)), tagc, tagc + 8'd1,
           1'b0, 1'b0, 16'h0, 16'h0);
      tagc += 8'(last_acc);
    end
    idle(6);
    check_order("wrap");
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      step(2'($urandom_range(0, 3)), 16'($urandom_range(690, 705)), 16'($urandom_range(690, 705)),
           tagc, tagc + 8'd1, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
           16'($urandom_range(690, 705)), 16'($urandom));
      tagc += 8'(last_acc);
    end
    idle(6);
    check_order("random");
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) begin
      ref_ram[i] = 16'(i * 37) ^ 16'h5A5A;
    end
    ref_ram[50] = 16'h1210;
    ref_ram[51] = 16'd2613;
    ref_ram[52] = 16'h1210;
    ref_ram[54] = 16'h1202;
    for (int i = 0; i < WORDS; i++) tb_ram[i] = ref_ram[i];
    req_valid   = 2'b00;
    req_address = '0;
    req_tag     = '0;
    rsp_stall   = 1'b0;
    wr_valid    = 1'b0;
    wr_address  = '0;
    wr_value    = '0;
    tagc        = 8'd0;
    test_reset();
    test_single_lane();
    test_dual_issue();
    test_forwarding();
    test_range();
    test_full_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
